// File: rtl/up_bus_pkg.sv
// up_bus_pkg: FSM encoding, timeout default and round-robin helper for the up_* bus arbiter
package up_bus_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEADDEAD;
  function automatic logic rr_win(input logic [1:0] pend, input logic ptr);
    return (pend == 2'b01) ? 1'b0 : (pend == 2'b10) ? 1'b1 : ptr;
  endfunction
endpackage

// File: rtl/up_bus_arbiter_if.sv
// up_bus_arbiter_if: master-facing and slave-facing up_* signals of the arbiter
interface up_bus_arbiter_if #(parameter int AW = 14);
  logic [1:0] m_wreq, m_wack, m_rreq, m_rack, timeout_err;
  logic [2*AW-1:0] m_waddr, m_raddr;
  logic [63:0] m_wdata, m_rdata;
  logic s_wreq, s_wack, s_rreq, s_rack;
  logic [AW-1:0] s_waddr, s_raddr;
  logic [31:0] s_wdata, s_rdata;
  modport arb (
    input  m_wreq, m_waddr, m_wdata, m_rreq, m_raddr, s_wack, s_rack, s_rdata,
    output m_wack, m_rack, m_rdata, s_wreq, s_waddr, s_wdata, s_rreq, s_raddr, timeout_err
  );
  modport master (
    output m_wreq, m_waddr, m_wdata, m_rreq, m_raddr,
    input  m_wack, m_rack, m_rdata, timeout_err
  );
  modport slave (
    input  s_wreq, s_waddr, s_wdata, s_rreq, s_raddr,
    output s_wack, s_rack, s_rdata
  );
endinterface

// File: rtl/up_bus_arb_channel.sv
// up_bus_arb_channel: one arbitrated channel with two pending slots, round-robin pointer and ack timeout
module up_bus_arb_channel
  import up_bus_pkg::*;
#(
  parameter int          DW           = 14,
  parameter int          TIMEOUT      = 64,
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_i,
  input  logic [2*DW-1:0] pay_i,
  output logic            s_req_o,
  output logic [DW-1:0]   s_pay_o,
  input  logic            s_ack_i,
  input  logic [31:0]     s_ret_i,
  output logic [1:0]      ack_o,
  output logic [63:0]     ret_o,
  output logic            err_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  logic [1:0] pend_q, pend_d, ack_q, ack_d;
  logic [1:0][DW-1:0] pay_q, pay_d;
  logic [DW-1:0] s_pay_q, s_pay_d;
  logic [63:0] ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic win_q, win_d, ptr_q, ptr_d, err_q, err_d, done;
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    s_pay_d = s_pay_q;
    ack_d = '0;
    ret_d = '0;
    pend_d = pend_q | req_i;
    for (int i = 0; i < 2; i++) pay_d[i] = (req_i[i] && !pend_q[i]) ? pay_i[i*DW +: DW] : pay_q[i];
    done = (state_q == WAIT) && (s_ack_i || cnt_q == '0);
    unique case (state_q)
      IDLE: if (|pend_q) begin
        win_d = rr_win(pend_q, ptr_q);
        // only a contested grant moves priority; a lone requester does not consume it
        ptr_d = (pend_q == 2'b11) ? ~win_d : ptr_q;
        s_pay_d = pay_q[win_d];
        state_d = ISSUE;
      end
      ISSUE: begin
        pend_d[win_q] = 1'b0;
        cnt_d = CW'(TIMEOUT);
        state_d = WAIT;
      end
      WAIT: if (done) begin
        ack_d[win_q] = 1'b1;
        ret_d[{win_q, 5'd0} +: 32] = s_ack_i ? s_ret_i : TIMEOUT_DATA;
        err_d = err_q | !s_ack_i;
        state_d = IDLE;
      end else cnt_d = cnt_q - CW'(1);
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      pay_q <= '0;
      s_pay_q <= '0;
      ack_q <= '0;
      ret_q <= '0;
      cnt_q <= '0;
      win_q <= 1'b0;
      ptr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      pay_q <= pay_d;
      s_pay_q <= s_pay_d;
      ack_q <= ack_d;
      ret_q <= ret_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  assign s_req_o = (state_q == ISSUE);
  assign s_pay_o = s_pay_q;
  assign ack_o = ack_q;
  assign ret_o = ret_q;
  assign err_o = err_q;
endmodule

// File: rtl/up_bus_arbiter.sv
// up_bus_arbiter: shares one up_* register slave between two masters, read and write arbitrated independently
module up_bus_arbiter
  import up_bus_pkg::*;
#(
  parameter int          AW           = 14,
  parameter int          TIMEOUT      = 64,
  parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
  input  logic              up_clk,
  input  logic              up_rst,
  up_bus_arbiter_if.arb     bus
);
  localparam int WW = AW + 32;
  logic [2*WW-1:0] w_pay;
  logic [WW-1:0] w_s_pay;
  logic [63:0] unused_wret;
  assign w_pay = {bus.m_wdata[63:32], bus.m_waddr[2*AW-1:AW], bus.m_wdata[31:0], bus.m_waddr[AW-1:0]};
  assign {bus.s_wdata, bus.s_waddr} = w_s_pay;
  up_bus_arb_channel #(.DW(WW), .TIMEOUT(TIMEOUT), .TIMEOUT_DATA(TIMEOUT_DATA)) u_wr (
    .clk(up_clk), .rst(up_rst),
    .req_i(bus.m_wreq), .pay_i(w_pay),
    .s_req_o(bus.s_wreq), .s_pay_o(w_s_pay),
    .s_ack_i(bus.s_wack), .s_ret_i(32'h0),
    .ack_o(bus.m_wack), .ret_o(unused_wret), .err_o(bus.timeout_err[0])
  );
  up_bus_arb_channel #(.DW(AW), .TIMEOUT(TIMEOUT), .TIMEOUT_DATA(TIMEOUT_DATA)) u_rd (
    .clk(up_clk), .rst(up_rst),
    .req_i(bus.m_rreq), .pay_i(bus.m_raddr),
    .s_req_o(bus.s_rreq), .s_pay_o(bus.s_raddr),
    .s_ack_i(bus.s_rack), .s_ret_i(bus.s_rdata),
    .ack_o(bus.m_rack), .ret_o(bus.m_rdata), .err_o(bus.timeout_err[1])
  );
endmodule

// File: tb/tb_up_bus_arbiter.sv
// tb_up_bus_arbiter: directed vector table plus hand-written multi-cycle sequences for up_bus_arbiter
module tb_up_bus_arbiter;
  localparam int AW = 14;
  localparam int TO = 64;
  localparam logic [31:0] JUNK = 32'hBAD0BAD0;
  typedef struct {
    logic rd;
    logic m;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    int lat;
    logic [31:0] rdata;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  vec_t vecs[6];
  vec_t vpost;
  logic acc;
  always #5 clk = ~clk;
  up_bus_arbiter_if #(.AW(AW)) bus ();
  up_bus_arbiter #(.AW(AW), .TIMEOUT(TO), .TIMEOUT_DATA(32'hDEADDEAD)) dut (
    .up_clk(clk), .up_rst(rst), .bus(bus)
  );
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rack_pulse(input logic [31:0] d);
    bus.s_rack = 1'b1;
    bus.s_rdata = d;
    tick;
    bus.s_rack = 1'b0;
    bus.s_rdata = JUNK;
  endtask
  task automatic run_vec(input vec_t v, input string tag);
    logic [1:0] oh;
    logic early;
    oh = v.m ? 2'b10 : 2'b01;
    early = 1'b0;
    if (v.rd) begin
      bus.m_rreq = oh;
      bus.m_raddr = v.m ? {v.addr, ~v.addr} : {~v.addr, v.addr};
    end else begin
      bus.m_wreq = oh;
      bus.m_waddr = v.m ? {v.addr, ~v.addr} : {~v.addr, v.addr};
      bus.m_wdata = v.m ? {v.wdata, ~v.wdata} : {~v.wdata, v.wdata};
    end
    tick;
    bus.m_rreq = '0;
    bus.m_wreq = '0;
    tick;
    if (v.rd) begin
      chk({tag, " s_rreq"}, 64'(bus.s_rreq), 64'd1);
      chk({tag, " s_raddr"}, 64'(bus.s_raddr), 64'(v.addr));
    end else begin
      chk({tag, " s_wreq"}, 64'(bus.s_wreq), 64'd1);
      chk({tag, " s_waddr"}, 64'(bus.s_waddr), 64'(v.addr));
      chk({tag, " s_wdata"}, 64'(bus.s_wdata), 64'(v.wdata));
    end
    repeat (v.lat) begin
      tick;
      early = early | (|bus.m_rack) | (|bus.m_wack);
    end
    chk({tag, " early ack"}, 64'(early), 64'd0);
    if (v.rd) begin
      rack_pulse(v.rdata);
      chk({tag, " m_rack"}, 64'(bus.m_rack), 64'(oh));
      chk({tag, " m_wack"}, 64'(bus.m_wack), 64'd0);
      chk({tag, " m_rdata"}, bus.m_rdata, v.m ? {v.rdata, 32'h0} : {32'h0, v.rdata});
    end else begin
      bus.s_wack = 1'b1;
      tick;
      bus.s_wack = 1'b0;
      chk({tag, " m_wack"}, 64'(bus.m_wack), 64'(oh));
      chk({tag, " m_rack"}, 64'(bus.m_rack), 64'd0);
    end
    tick;
    chk({tag, " acks drop"}, 64'({bus.m_wack, bus.m_rack}), 64'd0);
    chk({tag, " rdata idle"}, bus.m_rdata, 64'd0);
  endtask
  initial begin
    bus.m_wreq = '0;
    bus.m_rreq = '0;
    bus.m_waddr = '0;
    bus.m_raddr = '0;
    bus.m_wdata = '0;
    bus.s_wack = 1'b0;
    bus.s_rack = 1'b0;
    bus.s_rdata = JUNK;
    vecs[0] = '{rd: 1'b1, m: 1'b0, addr: 14'h0003, wdata: 32'h0, lat: 1, rdata: 32'h53594944};
    vecs[1] = '{rd: 1'b1, m: 1'b1, addr: 14'h0005, wdata: 32'h0, lat: 3, rdata: 32'h12345678};
    vecs[2] = '{rd: 1'b0, m: 1'b0, addr: 14'h0002, wdata: 32'hA5A5A5A5, lat: 1, rdata: 32'h0};
    vecs[3] = '{rd: 1'b0, m: 1'b1, addr: 14'h3FFF, wdata: 32'hFFFFFFFF, lat: 2, rdata: 32'h0};
    vecs[4] = '{rd: 1'b1, m: 1'b1, addr: 14'h3FFF, wdata: 32'h0, lat: 1, rdata: 32'h00000000};
    vecs[5] = '{rd: 1'b1, m: 1'b0, addr: 14'h0000, wdata: 32'h0, lat: 5, rdata: 32'hCAFEBABE};
    vpost = '{rd: 1'b1, m: 1'b1, addr: 14'h000A, wdata: 32'h0, lat: 2, rdata: 32'h0BADF00D};
    repeat (3) tick;
    chk("rst acks", 64'({bus.m_wack, bus.m_rack}), 64'd0);
    chk("rst m_rdata", bus.m_rdata, 64'd0);
    chk("rst s_reqs", 64'({bus.s_wreq, bus.s_rreq}), 64'd0);
    chk("rst s_addrs", 64'({bus.s_waddr, bus.s_raddr}), 64'd0);
    chk("rst s_wdata", 64'(bus.s_wdata), 64'd0);
    chk("rst timeout_err", 64'(bus.timeout_err), 64'd0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      tick;
    end
    // contention: first pair from the reset pointer goes m0 then m1
    bus.m_rreq = 2'b11;
    bus.m_raddr = {14'h002, 14'h000};
    tick;
    bus.m_rreq = '0;
    tick;
    chk("rr0 s_rreq", 64'(bus.s_rreq), 64'd1);
    chk("rr0 s_raddr", 64'(bus.s_raddr), 64'h000);
    tick;
    rack_pulse(32'h11111111);
    chk("rr0 m_rack", 64'(bus.m_rack), 64'b01);
    chk("rr0 m_rdata", bus.m_rdata, {32'h0, 32'h11111111});
    tick;
    chk("rr1 s_rreq", 64'(bus.s_rreq), 64'd1);
    chk("rr1 s_raddr", 64'(bus.s_raddr), 64'h002);
    tick;
    rack_pulse(32'h22222222);
    chk("rr1 m_rack", 64'(bus.m_rack), 64'b10);
    chk("rr1 m_rdata", bus.m_rdata, {32'h22222222, 32'h0});
    tick;
    bus.m_rreq = 2'b11;
    bus.m_raddr = {14'h011, 14'h010};
    tick;
    bus.m_rreq = '0;
    tick;
    chk("rr2 s_raddr", 64'(bus.s_raddr), 64'h011);
    tick;
    rack_pulse(32'h33333333);
    chk("rr2 m_rack", 64'(bus.m_rack), 64'b10);
    chk("rr2 m_rdata", bus.m_rdata, {32'h33333333, 32'h0});
    tick;
    chk("rr3 s_rreq", 64'(bus.s_rreq), 64'd1);
    chk("rr3 s_raddr", 64'(bus.s_raddr), 64'h010);
    tick;
    rack_pulse(32'h44444444);
    chk("rr3 m_rack", 64'(bus.m_rack), 64'b01);
    chk("rr3 m_rdata", bus.m_rdata, {32'h0, 32'h44444444});
    tick;
    // concurrent write (m0) and read (m1)
    bus.m_wreq = 2'b01;
    bus.m_waddr = {14'h1234, 14'h002};
    bus.m_wdata = {32'h0, 32'hA5A5A5A5};
    bus.m_rreq = 2'b10;
    bus.m_raddr = {14'h002, 14'h3333};
    tick;
    bus.m_wreq = '0;
    bus.m_rreq = '0;
    tick;
    chk("cc s_reqs", 64'({bus.s_wreq, bus.s_rreq}), 64'b11);
    chk("cc s_waddr", 64'(bus.s_waddr), 64'h002);
    chk("cc s_wdata", 64'(bus.s_wdata), 64'hA5A5A5A5);
    chk("cc s_raddr", 64'(bus.s_raddr), 64'h002);
    tick;
    bus.s_wack = 1'b1;
    bus.s_rack = 1'b1;
    bus.s_rdata = 32'hA5A5A5A5;
    tick;
    bus.s_wack = 1'b0;
    bus.s_rack = 1'b0;
    bus.s_rdata = JUNK;
    chk("cc m_wack", 64'(bus.m_wack), 64'b01);
    chk("cc m_rack", 64'(bus.m_rack), 64'b10);
    chk("cc m_rdata", bus.m_rdata, {32'hA5A5A5A5, 32'h0});
    tick;
    chk("cc single ack", 64'({bus.m_wack, bus.m_rack}), 64'd0);
    tick;
    // second rreq while the first is still pending must be dropped
    bus.m_rreq = 2'b01;
    bus.m_raddr = {14'h0, 14'h010};
    tick;
    bus.m_raddr = {14'h0, 14'h020};
    tick;
    bus.m_rreq = '0;
    chk("pv s_rreq", 64'(bus.s_rreq), 64'd1);
    chk("pv s_raddr", 64'(bus.s_raddr), 64'h010);
    tick;
    rack_pulse(32'h55555555);
    chk("pv m_rack", 64'(bus.m_rack), 64'b01);
    chk("pv m_rdata", bus.m_rdata, {32'h0, 32'h55555555});
    acc = 1'b0;
    repeat (10) begin
      tick;
      acc = acc | bus.s_rreq | (|bus.m_rack);
    end
    chk("pv no second xfer", 64'(acc), 64'd0);
    // m1 read with a dead slave: slave gets TO+1 WAIT cycles, then the timeout ack
    bus.m_rreq = 2'b10;
    bus.m_raddr = {14'h007, 14'h2AAA};
    tick;
    bus.m_rreq = '0;
    tick;
    chk("to s_raddr", 64'(bus.s_raddr), 64'h007);
    acc = 1'b0;
    repeat (TO + 1) begin
      tick;
      acc = acc | (|bus.m_rack);
    end
    chk("to early ack", 64'(acc), 64'd0);
    tick;
    chk("to m_rack", 64'(bus.m_rack), 64'b10);
    chk("to m_rdata", bus.m_rdata, {32'hDEADDEAD, 32'h0});
    chk("to timeout_err", 64'(bus.timeout_err), 64'b10);
    repeat (4) tick;
    rack_pulse(32'h66666666);
    acc = |bus.m_rack;
    repeat (4) begin
      tick;
      acc = acc | (|bus.m_rack);
    end
    chk("to late ack ignored", 64'(acc), 64'd0);
    chk("to err sticky", 64'(bus.timeout_err), 64'b10);
    // reset while m0 waits on a read
    bus.m_rreq = 2'b01;
    bus.m_raddr = {14'h2AAA, 14'h009};
    tick;
    bus.m_rreq = '0;
    tick;
    chk("rw s_raddr", 64'(bus.s_raddr), 64'h009);
    tick;
    rst = 1'b1;
    #1;
    chk("rw s_raddr cleared", 64'(bus.s_raddr), 64'd0);
    chk("rw timeout_err cleared", 64'(bus.timeout_err), 64'd0);
    chk("rw acks", 64'({bus.m_wack, bus.m_rack, bus.s_wreq, bus.s_rreq}), 64'd0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    rack_pulse(32'h77777777);
    acc = |bus.m_rack;
    repeat (5) begin
      tick;
      acc = acc | (|bus.m_rack) | bus.s_rreq;
    end
    chk("rw no ack after release", 64'(acc), 64'd0);
    run_vec(vpost, "post");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/up_bus_arbiter.md
Name: up_bus_arbiter

Overview:
- Shares one up_* register-bus slave between two up_* masters, for example the AXI bridge (up_axi) and a local boot/ID sequencer.
- The slave is a register core such as the system-ID/ROM block.
- Read and write channels are arbitrated independently: each channel is round-robin with one outstanding transfer per channel.
- Each channel has a no-ack timeout, so a dead slave cannot hang either master.

Parameters:
- AW, 14, up address width.
- TIMEOUT, 64, slave-ack wait limit in cycles per transfer (≥2).
- TIMEOUT_DATA, 32'hDEADDEAD, rdata returned to the master on read timeout.

Ports:
- up_clk  in  1  clock; all logic is on this rising edge.
- up_rst  in  1  asynchronous, active-high reset.
- m_wreq  in  2  per-master write request pulse; bit i is master i.
- m_waddr  in  2*AW  master i address at [i*AW +: AW].
- m_wdata  in  64  master i data at [i*32 +: 32].
- m_wack  out  2  write ack pulse to master i.
- m_rreq  in  2  read request pulse.
- m_raddr  in  2*AW  read address.
- m_rdata  out  64  read data; valid only with the matching m_rack bit.
- m_rack  out  2  read ack pulse.
- s_wreq / s_waddr / s_wdata  out  1 / AW / 32  to slave.
- s_wack  in  1  from slave.
- s_rreq / s_raddr  out  1 / AW  to slave.
- s_rdata / s_rack  in  32 / 1  from slave.
- timeout_err  out  2  sticky flags: bit0 write-channel timeout, bit1 read-channel timeout; cleared only by reset.

Behaviour:
- Protocol: req/ack are single-cycle pulses. A master never issues a second req of the same type before receiving the ack. It may have one read and one write outstanding at the same time.
- Pending slots: there are four (m0w, m0r, m1w, m1r). A slot is set in the cycle after its req pulse, latching address and data.
  - A req arriving while the same slot is already pending is a protocol violation: it is dropped and the latched transfer is kept.
- Per-channel FSM, identical for the read and write channels:
  - IDLE: if any slot of this channel is pending, select the winner by round-robin, go to ISSUE.
  - ISSUE: drive s_*req=1 for exactly one cycle with the winner's addr/data, clear the winner's slot, load the timeout counter, go to WAIT.
  - WAIT: on s_*ack, register the ack to the winner's m_*ack bit (and s_rdata to its m_rdata lane) the next cycle, go to IDLE.
    - If the counter reaches 0 first: return an ack to the winner (read data = TIMEOUT_DATA), set timeout_err, go to IDLE.
- Latency: master req at cycle t → s_req at t+2. Slave ack at cycle a → master ack at a+1. Minimum round trip is 4 cycles with a 1-cycle slave.
- Round-robin: one priority pointer per channel, reset to favour master 0. After a grant, priority passes to the other master. If only one slot is pending it wins regardless of the pointer.
- Simultaneous requests at reset from both masters → m0 is served first, m1 next.
- Stray slave acks (any s_*ack outside WAIT, including late acks after a timeout) are ignored.
- Read and write channels never interact; simultaneous s_wreq and s_rreq is legal.
- Outputs when idle: m_rdata lanes are 0 except in the m_rack cycle; s_wdata and s_*addr hold their last value and are don't-care without req.
- Reset values: all outputs 0, slots empty, FSMs IDLE, pointers favour m0, counters 0, timeout_err=0.
- Reset mid-transfer: in-flight and pending transfers are discarded and no acks are generated. An s_*ack arriving after reset release is treated as stray.
- Timeout counter is clog2(TIMEOUT+1) bits, decrements only in WAIT, never wraps.

Decomposition:
- Shared package up_bus_pkg holds:
  - the FSM state encoding (IDLE/ISSUE/WAIT);
  - the TIMEOUT_DATA default;
  - a function computing the round-robin winner from (pending[1:0], pointer).
- The natural sub-module is up_bus_arb_channel: one FSM, two slots, pointer and timeout counter, parameterised by data width.
  - Instantiated twice: write channel carries addr+wdata; read channel carries addr with a return-data path.

Test Plan:
- Single read: m0 reads addr 0x003, slave acks after 1 cycle with 0x53594944 → m_rack[0] one cycle later, m_rdata[31:0]=0x53594944, m_rack[1]=0.
- Contention: m0 and m1 rreq in the same cycle (addr 0x000, 0x002) → s_raddr=0x000 first, then 0x002 after the first ack; next simultaneous pair serves m1 first.
- Concurrent channels: m0 writes 0x002←0xA5A5A5A5 while m1 reads 0x002 → s_wreq and s_rreq overlap; each master gets exactly one ack on its own bit.
- Timeout: slave never acks a m1 read → m_rack[1] after TIMEOUT cycles with 0xDEADDEAD and timeout_err[1]=1. A slave ack arriving 5 cycles later produces no m_rack.
- Reset mid-WAIT: assert up_rst while m0 is waiting on a read → all outputs 0 at once, no m_rack after release. A subsequent m1 read completes normally.
- Protocol violation: m0 pulses rreq twice (addrs 0x010, 0x020) before its ack → only 0x010 reaches the slave and exactly one ack is returned.
